// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared types and defaults for the shift register sequencer
//
// Purpose: default widths, direction encodings and the FSM state type
//          used by shift_reg_sequencer and shift_gap_timer.
// Ports:   none (package).
package shift_seq_pkg;

  localparam int DEF_SREG_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 4;
  localparam int DEF_GAP_WIDTH  = 8;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_SETTLE = 3'd4,
    ST_RESP   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/shift_gap_timer.sv
// rtl/shift_gap_timer.sv - down-counter timing the idle gap between shift pulses
//
// Purpose: loads the gap length when the sequencer heads into GAP and
//          counts it down; done marks the last GAP cycle.
// Ports:
//   aclk, aresetn  clock, asynchronous active-low reset
//   load           load load_value into the counter on the next edge
//   load_value     number of gap cycles
//   done           high in the final gap cycle (counter == 1)
module shift_gap_timer
  import shift_seq_pkg::*;
#(
  parameter int GAP_WIDTH = DEF_GAP_WIDTH
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 load,
  input  logic [GAP_WIDTH-1:0] load_value,
  output logic                 done
);

  logic [GAP_WIDTH-1:0] count;

  // Counter parks at zero once the gap has elapsed.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - GAP_WIDTH'(1);
    end
  end

  assign done = (count == GAP_WIDTH'(1));

endmodule

// File: rtl/shift_reg_sequencer.sv
// rtl/shift_reg_sequencer.sv - command-driven serial loader for the shift register
//
// Purpose: accepts one command (data, bit count, direction, gap), emits one
//          en pulse per bit (data LSB first) and returns the sampled q.
// Ports:
//   aclk, aresetn                   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_data/cmd_count/cmd_dir/cmd_gap  command fields
//   rsp_valid/rsp_ready/rsp_q       response handshake and sampled q
//   busy                            high whenever not IDLE
//   dir/din/en                      registered controls to the shift register
//   q                               shift register parallel output
module shift_reg_sequencer
  import shift_seq_pkg::*;
#(
  parameter int SREG_WIDTH = DEF_SREG_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int GAP_WIDTH  = DEF_GAP_WIDTH
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [CNT_WIDTH-1:0]  cmd_count,
  input  logic                  cmd_dir,
  input  logic [GAP_WIDTH-1:0]  cmd_gap,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [SREG_WIDTH-1:0] rsp_q,
  output logic                  busy,
  output logic                  dir,
  output logic                  din,
  output logic                  en,
  input  logic [SREG_WIDTH-1:0] q
);

  seq_state_t            state, state_nxt;
  logic [DATA_WIDTH-1:0] data_sh, data_nxt;
  logic [CNT_WIDTH-1:0]  remaining, remaining_nxt;
  logic [CNT_WIDTH-1:0]  count_clamped;
  logic [GAP_WIDTH-1:0]  gap_r;
  logic                  cmd_fire;
  logic                  gap_load;
  logic                  gap_done;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign cmd_fire  = cmd_valid && cmd_ready;

  assign count_clamped = (cmd_count > CNT_WIDTH'(DATA_WIDTH)) ? CNT_WIDTH'(DATA_WIDTH)
                                                              : cmd_count;

  shift_gap_timer #(
    .GAP_WIDTH (GAP_WIDTH)
  ) u_gap_timer (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .load       (gap_load),
    .load_value (gap_r),
    .done       (gap_done)
  );

  always_comb begin
    state_nxt     = state;
    data_nxt      = data_sh;
    remaining_nxt = remaining;
    gap_load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          data_nxt      = cmd_data;
          remaining_nxt = count_clamped;
          state_nxt     = (count_clamped != '0) ? ST_SETUP : ST_SETTLE;
        end
      end
      ST_SETUP: state_nxt = ST_PULSE;
      ST_PULSE: begin
        data_nxt      = data_sh >> 1;
        remaining_nxt = remaining - CNT_WIDTH'(1);
        if (remaining_nxt == '0) begin
          state_nxt = ST_SETTLE;
        end else if (gap_r != '0) begin
          state_nxt = ST_GAP;
          gap_load  = 1'b1;
        end else begin
          state_nxt = ST_SETUP;
        end
      end
      ST_GAP: begin
        if (gap_done) state_nxt = ST_SETUP;
      end
      ST_SETTLE: state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // din is updated on the edge into SETUP so it is already stable for the
  // whole SETUP cycle and does not move on the edge that raises en.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      data_sh   <= '0;
      remaining <= '0;
      gap_r     <= '0;
      dir       <= DIR_LEFT;
      din       <= 1'b0;
      en        <= 1'b0;
      rsp_q     <= '0;
    end else begin
      state     <= state_nxt;
      data_sh   <= data_nxt;
      remaining <= remaining_nxt;
      en        <= (state_nxt == ST_PULSE);
      if (cmd_fire) begin
        dir   <= cmd_dir;
        gap_r <= cmd_gap;
      end
      if (state_nxt == ST_SETUP) begin
        din <= data_nxt[0];
      end
      // Final shift has landed on q by the SETTLE cycle.
      if (state == ST_SETTLE) begin
        rsp_q <= q;
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// tb/tb_shift_reg_sequencer.sv - directed self-checking bench for shift_reg_sequencer
module tb_shift_reg_sequencer;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = '0;
  logic [3:0] cmd_count = '0;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_gap = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_q;
  logic       busy;
  logic       dir;
  logic       din;
  logic       en;
  logic [3:0] q;

  logic       q_load = 1'b0;
  logic [3:0] q_load_val = '0;

  int cyc = 0;
  int ncomp = 0;
  int nfail = 0;

  int   pc[0:15];
  logic pd[0:15];
  int   np;
  int   rc;
  int   stab_err;
  int   b2b_err;
  int   busy_acc;

  shift_reg_sequencer dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .cmd_dir   (cmd_dir),
    .cmd_gap   (cmd_gap),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_q     (rsp_q),
    .busy      (busy),
    .dir       (dir),
    .din       (din),
    .en        (en),
    .q         (q)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Behavioural 4-bit shift register driven by the DUT.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn)    q <= '0;
    else if (q_load) q <= q_load_val;
    else if (en)     q <= dir ? {din, q[3:1]} : {q[2:0], din};
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preset_q(input logic [3:0] v);
    @(negedge aclk);
    q_load = 1'b1;
    q_load_val = v;
    @(negedge aclk);
    q_load = 1'b0;
  endtask

  // Issues one command at a negedge (cycle 0) and records, relative to the
  // handshake cycle, every en pulse and the first rsp_valid cycle.
  task automatic run_cmd(input logic [7:0] d, input logic [3:0] c, input logic dr,
                         input logic [7:0] g, input logic hold_valid);
    int t0;
    int rel;
    logic pdin, pdir, pen;
    np = 0; rc = -1; stab_err = 0; b2b_err = 0; busy_acc = 0;
    @(negedge aclk);
    cmd_data = d; cmd_count = c; cmd_dir = dr; cmd_gap = g; cmd_valid = 1'b1;
    ncomp++;
    if (cmd_ready !== 1'b1) begin
      nfail++;
      $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
    end
    t0 = cyc; pdin = din; pdir = dir; pen = en;
    @(negedge aclk);
    if (hold_valid) begin
      cmd_data = 8'hFF; cmd_count = 4'd1; cmd_dir = ~dr;
    end else begin
      cmd_valid = 1'b0;
    end
    for (int k = 1; k < 300; k++) begin
      rel = cyc - t0;
      if (en) begin
        if (np < 16) begin pc[np] = rel; pd[np] = din; end
        np++;
        if (din !== pdin || dir !== pdir) stab_err++;
        if (pen) b2b_err++;
      end
      if (hold_valid && cmd_ready) busy_acc++;
      pen = en; pdin = din; pdir = dir;
      if (rsp_valid) begin
        rc = rel;
        break;
      end
      @(negedge aclk);
    end
    cmd_valid = 1'b0;
    ncomp++;
    if (rc < 0) begin
      nfail++;
      $display("FAIL rsp_timeout: got no rsp_valid within 300 cycles, want one");
    end
  endtask

  task automatic pop_rsp();
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    ncomp++;
    if ({cmd_ready, busy, en, rsp_valid, dir, din} !== 6'b100000) begin
      nfail++;
      $display("FAIL reset_ctrl: got rdy/busy/en/rv/dir/din=%b want 100000",
               {cmd_ready, busy, en, rsp_valid, dir, din});
    end
    ncomp++;
    if (rsp_q !== 4'b0000) begin
      nfail++;
      $display("FAIL reset_rsp_q: got %b want 0000", rsp_q);
    end
  endtask

  task automatic test_left_gap0();
    int   exp_c[4] = '{2, 4, 6, 8};
    logic [3:0] exp_d = 4'b1011;
    preset_q(4'b0000);
    run_cmd(8'h0B, 4'd4, 1'b0, 8'd0, 1'b0);
    ncomp++;
    if (np !== 4) begin nfail++; $display("FAIL left_npulse: got %0d want 4", np); end
    for (int i = 0; i < 4; i++) begin
      ncomp++;
      if (pc[i] !== exp_c[i] || pd[i] !== exp_d[i]) begin
        nfail++;
        $display("FAIL left_pulse%0d: got cycle %0d din %b want cycle %0d din %b",
                 i, pc[i], pd[i], exp_c[i], exp_d[i]);
      end
    end
    ncomp++;
    if (rc !== 10) begin nfail++; $display("FAIL left_latency: got %0d want 10", rc); end
    ncomp++;
    if (rsp_q !== 4'b1101) begin nfail++; $display("FAIL left_rsp_q: got %b want 1101", rsp_q); end
    ncomp++;
    if (stab_err !== 0 || b2b_err !== 0) begin
      nfail++;
      $display("FAIL left_en_rules: got stab %0d b2b %0d want 0 0", stab_err, b2b_err);
    end
    pop_rsp();
  endtask

  task automatic test_right_gap3();
    int   exp_c[4] = '{2, 7, 12, 17};
    logic [3:0] exp_d = 4'b1011;
    preset_q(4'b0000);
    run_cmd(8'h0B, 4'd4, 1'b1, 8'd3, 1'b0);
    ncomp++;
    if (np !== 4) begin nfail++; $display("FAIL right_npulse: got %0d want 4", np); end
    for (int i = 0; i < 4; i++) begin
      ncomp++;
      if (pc[i] !== exp_c[i] || pd[i] !== exp_d[i]) begin
        nfail++;
        $display("FAIL right_pulse%0d: got cycle %0d din %b want cycle %0d din %b",
                 i, pc[i], pd[i], exp_c[i], exp_d[i]);
      end
    end
    ncomp++;
    if (rc !== 19) begin nfail++; $display("FAIL right_latency: got %0d want 19", rc); end
    ncomp++;
    if (rsp_q !== 4'b1011) begin nfail++; $display("FAIL right_rsp_q: got %b want 1011", rsp_q); end
    ncomp++;
    if (stab_err !== 0 || b2b_err !== 0) begin
      nfail++;
      $display("FAIL right_en_rules: got stab %0d b2b %0d want 0 0", stab_err, b2b_err);
    end
    pop_rsp();
  endtask

  task automatic test_count0();
    preset_q(4'b0110);
    run_cmd(8'hFF, 4'd0, 1'b1, 8'd2, 1'b0);
    ncomp++;
    if (np !== 0) begin nfail++; $display("FAIL cnt0_npulse: got %0d want 0", np); end
    ncomp++;
    if (rc !== 2) begin nfail++; $display("FAIL cnt0_latency: got %0d want 2", rc); end
    ncomp++;
    if (rsp_q !== 4'b0110) begin nfail++; $display("FAIL cnt0_rsp_q: got %b want 0110", rsp_q); end
    pop_rsp();
  endtask

  task automatic test_clamp_busy();
    int   exp_c[8] = '{2, 4, 6, 8, 10, 12, 14, 16};
    logic [7:0] exp_d = 8'hA5;
    preset_q(4'b0000);
    run_cmd(8'hA5, 4'd15, 1'b0, 8'd0, 1'b1);
    ncomp++;
    if (np !== 8) begin nfail++; $display("FAIL clamp_npulse: got %0d want 8", np); end
    for (int i = 0; i < 8; i++) begin
      ncomp++;
      if (pc[i] !== exp_c[i] || pd[i] !== exp_d[i]) begin
        nfail++;
        $display("FAIL clamp_pulse%0d: got cycle %0d din %b want cycle %0d din %b",
                 i, pc[i], pd[i], exp_c[i], exp_d[i]);
      end
    end
    ncomp++;
    if (rc !== 18) begin nfail++; $display("FAIL clamp_latency: got %0d want 18", rc); end
    ncomp++;
    if (rsp_q !== 4'b0101) begin nfail++; $display("FAIL clamp_rsp_q: got %b want 0101", rsp_q); end
    ncomp++;
    if (busy_acc !== 0) begin
      nfail++;
      $display("FAIL busy_cmd_ready: got %0d ready cycles while busy want 0", busy_acc);
    end
    pop_rsp();
    ncomp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL clamp_back_idle: got ready %b busy %b want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_rsp_hold();
    int viol = 0;
    preset_q(4'b0000);
    run_cmd(8'h0B, 4'd4, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      q_load = (i == 5);
      q_load_val = 4'b1111;
      if (rsp_valid !== 1'b1 || rsp_q !== 4'b1101 || cmd_ready !== 1'b0) viol++;
    end
    q_load = 1'b0;
    ncomp++;
    if (viol !== 0) begin
      nfail++;
      $display("FAIL hold_stable: got %0d unstable cycles want 0 (rsp_q %b)", viol, rsp_q);
    end
    pop_rsp();
    ncomp++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL hold_release: got ready %b rv %b busy %b want 1 0 0",
               cmd_ready, rsp_valid, busy);
    end
  endtask

  task automatic test_reset_mid_gap();
    preset_q(4'b0000);
    @(negedge aclk);
    cmd_data = 8'h0B; cmd_count = 4'd4; cmd_dir = 1'b1; cmd_gap = 8'd3; cmd_valid = 1'b1;
    @(negedge aclk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge aclk);
    ncomp++;
    if (busy !== 1'b1 || en !== 1'b0) begin
      nfail++;
      $display("FAIL gap_busy: got busy %b en %b want 1 0", busy, en);
    end
    #2;
    aresetn = 1'b0;
    #1;
    ncomp++;
    if ({en, rsp_valid, busy, cmd_ready, dir, din} !== 6'b000100) begin
      nfail++;
      $display("FAIL async_reset: got en/rv/busy/rdy/dir/din=%b want 000100",
               {en, rsp_valid, busy, cmd_ready, dir, din});
    end
    ncomp++;
    if (rsp_q !== 4'b0000) begin nfail++; $display("FAIL async_reset_rsp_q: got %b want 0000", rsp_q); end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    run_cmd(8'h01, 4'd1, 1'b0, 8'd5, 1'b0);
    ncomp++;
    if (np !== 1 || pc[0] !== 2 || pd[0] !== 1'b1) begin
      nfail++;
      $display("FAIL post_reset_pulse: got n %0d cycle %0d din %b want 1 2 1", np, pc[0], pd[0]);
    end
    ncomp++;
    if (rc !== 4 || rsp_q !== 4'b0001) begin
      nfail++;
      $display("FAIL post_reset_rsp: got cycle %0d q %b want 4 0001", rc, rsp_q);
    end
    pop_rsp();
    ncomp++;
    if (cmd_ready !== 1'b1) begin nfail++; $display("FAIL post_reset_idle: got %b want 1", cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_left_gap0();
    test_right_gap3();
    test_count0();
    test_clamp_busy();
    test_rsp_hold();
    test_reset_mid_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/shift_reg_sequencer.md
Name: shift_reg_sequencer

Overview:
- Command-driven controller that serially loads the 4-bit shift register through its dir/din/en controls.
- Accepts one command (data word, bit count, direction, inter-shift gap) over a valid/ready handshake and emits one en pulse per bit.
- After the last shift it samples q and returns it over a valid/ready response channel.
- Sits between a processor-side command source (AXI register front-end or DMA) and the shift register core, replacing direct software toggling of en.

Parameters:
- SREG_WIDTH, 4, width of shift register output q and of rsp_q.
- DATA_WIDTH, 8, maximum bits per command.
- CNT_WIDTH, 4, width of cmd_count; must satisfy 2^CNT_WIDTH > DATA_WIDTH.
- GAP_WIDTH, 8, width of the inter-shift gap field.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer idle, command accepted on cmd_valid&&cmd_ready
- cmd_data  in  DATA_WIDTH  bits to shift, sent LSB first
- cmd_count  in  CNT_WIDTH  number of bits to shift (0..DATA_WIDTH)
- cmd_dir  in  1  0 = shift left, 1 = shift right
- cmd_gap  in  GAP_WIDTH  idle cycles between consecutive en pulses
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed on rsp_valid&&rsp_ready
- rsp_q  out  SREG_WIDTH  sampled shift register contents
- busy  out  1  high whenever state != IDLE
- dir  out  1  shift direction to shift register
- din  out  1  serial data to shift register
- en  out  1  single-cycle shift enable
- q  in  SREG_WIDTH  shift register parallel output

Behaviour:
- Interface: one clock, aclk; reset aresetn is asynchronous, active-low.
- Reset, asynchronous and effective immediately, including mid-operation:
  - state=IDLE; dir, din, en, rsp_valid, busy = 0; rsp_q = 0.
  - cmd_ready = 1 (IDLE).
  - All latched command fields cleared.
  - No partial response is produced.
- dir, din, en and rsp_q are registered outputs. cmd_ready and busy are decoded from state.
- States: IDLE, SETUP, PULSE, GAP, SETTLE, RESP.
- IDLE: cmd_ready=1.
  - On handshake, latch cmd_data, dir (driven onto dir output), gap, and remaining = min(cmd_count, DATA_WIDTH).
  - remaining>0 -> SETUP; remaining==0 -> SETTLE.
- SETUP, one cycle:
  - din = current LSB of the data shift copy; en=0.
  - -> PULSE.
- PULSE, one cycle:
  - en=1, din and dir held stable.
  - Data copy shifts right by one; remaining decrements.
  - If remaining (after decrement) >0: -> GAP when gap>0, else -> SETUP.
  - If remaining==0: -> SETTLE.
- GAP: counts gap cycles (counter loaded with gap on entry) with en=0, then -> SETUP. gap=0 never enters GAP.
- SETTLE, one cycle:
  - en=0; allows the final shift to appear on q.
  - On exit, rsp_q <= q.
  - -> RESP.
- RESP:
  - rsp_valid=1, rsp_q held stable.
  - On rsp_ready -> IDLE. A new command can be accepted no earlier than the cycle after the response handshake.
- en is never high on two consecutive cycles. dir and din never change in a cycle where en=1.
- Latency, with the handshake in cycle 0:
  - count>0: rsp_valid first high in cycle 2*count + (count-1)*gap + 2.
  - count=0: rsp_valid first high in cycle 2.
- cmd_count > DATA_WIDTH is clamped to DATA_WIDTH.
- cmd_valid while busy is ignored (cmd_ready=0); the fields are not sampled.
- rsp_ready held low: stays in RESP indefinitely; rsp_q does not track q.
- dir and din retain their last values in IDLE; en=0 in every state except PULSE.

Decomposition:
- Package shift_seq_pkg:
  - State enumeration localparams (IDLE=0 .. RESP=5, 3-bit encoding).
  - Default widths SREG_WIDTH/DATA_WIDTH/CNT_WIDTH/GAP_WIDTH.
  - Direction constants DIR_LEFT=0, DIR_RIGHT=1.
- One sub-module, shift_gap_timer:
  - Load and count-down of the GAP counter with a done flag.
  - Reset asynchronous, active-low, identical to the parent.
- Remaining logic stays in the top-level FSM.

Test Plan:
Bench model: left shift q<={q[2:0],din}, right shift q<={din,q[3:1]} on aclk when en=1; q reset 0000.
- cmd_data=8'h0B, count=4, dir=0, gap=0 -> en pulses in cycles 2,4,6,8 with din=1,1,0,1; rsp_valid first in cycle 10; rsp_q=4'b1101.
- Same command with dir=1, gap=3 -> en pulses in cycles 2,7,12,17; rsp_valid first in cycle 19; rsp_q=4'b1011.
- count=0, q preset 4'b0110 -> no en pulse; rsp_valid in cycle 2; rsp_q=4'b0110.
- count=15 (clamped to 8), cmd_data=8'hA5, dir=0, gap=0 -> exactly 8 en pulses; rsp_q=4'b0101. A second cmd_valid asserted during busy is not accepted.
- rsp_ready held low 20 cycles after rsp_valid -> rsp_valid and rsp_q stable, cmd_ready=0; on rsp_ready=1, IDLE the next cycle and cmd_ready=1.
- aresetn asserted asynchronously mid-GAP of a 4-bit command -> en, rsp_valid, busy = 0 immediately; after release, cmd_ready=1 and a fresh count=1 command completes normally.
